// File: rtl/pacemaker_pkg.sv
// Shared pacing types and default output-stage timing (all in clk cycles).
package pacemaker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        DELIVER,
        RECHARGE,
        BLANK
    } pace_state_e;

    localparam int unsigned CHARGE_CYC_DEF   = 8;
    localparam int unsigned RECHARGE_CYC_DEF = 20;
    localparam int unsigned BLANK_CYC_DEF    = 400;
    localparam int unsigned MAX_PW_CYC_DEF   = 150;

    localparam int unsigned AMP_WIDTH = 4;

endpackage

// File: rtl/pace_output_sequencer_if.sv
// Request/config and output-stage control bundle for pace_output_sequencer.
interface pace_output_sequencer_if
    import pacemaker_pkg::*;
#(
    parameter int unsigned PW_WIDTH = 8
);
    logic                 enable;
    logic                 pace_req;
    logic                 test_req;
    logic [PW_WIDTH-1:0]  cfg_pw;
    logic [AMP_WIDTH-1:0] cfg_amp;

    logic                 charge_en;
    logic                 pulse_en;
    logic                 recharge_en;
    logic                 sense_blank;
    logic [AMP_WIDTH-1:0] amp_out;
    logic                 busy;
    logic                 src_test;
    logic                 pace_done;
    logic [7:0]           drop_cnt;

    modport master (
        output enable, pace_req, test_req, cfg_pw, cfg_amp,
        input  charge_en, pulse_en, recharge_en, sense_blank, amp_out,
               busy, src_test, pace_done, drop_cnt
    );

    modport slave (
        input  enable, pace_req, test_req, cfg_pw, cfg_amp,
        output charge_en, pulse_en, recharge_en, sense_blank, amp_out,
               busy, src_test, pace_done, drop_cnt
    );

endinterface

// File: rtl/pace_output_sequencer.sv
// Pacing output-stage sequencer: charge -> deliver -> recharge -> blank,
// arbitrating demand and test pace requests onto the single output stage.
module pace_output_sequencer
    import pacemaker_pkg::*;
#(
    parameter int unsigned CHARGE_CYC   = CHARGE_CYC_DEF,
    parameter int unsigned RECHARGE_CYC = RECHARGE_CYC_DEF,
    parameter int unsigned BLANK_CYC    = BLANK_CYC_DEF,
    parameter int unsigned MAX_PW_CYC   = MAX_PW_CYC_DEF,
    parameter int unsigned PW_WIDTH     = 8,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pace_output_sequencer_if.slave bus
);

    pace_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PW_WIDTH-1:0]  pw_eff_q, pw_eff_d;
    logic [AMP_WIDTH-1:0] amp_q, amp_d;
    logic                 src_q, src_d;
    logic                 delivered_q, delivered_d;
    logic [7:0]           drop_q, drop_d;
    logic                 done_q, done_d;
    logic                 charge_q, pulse_q, recharge_q, blank_q, busy_q;

    logic [PW_WIDTH-1:0]  pw_clamped;
    logic [1:0]           drop_inc;
    logic [8:0]           drop_sum;

    always_comb begin
        if (bus.cfg_pw == '0) begin
            pw_clamped = PW_WIDTH'(1);
        end else if (32'(bus.cfg_pw) > MAX_PW_CYC) begin
            pw_clamped = PW_WIDTH'(MAX_PW_CYC);
        end else begin
            pw_clamped = bus.cfg_pw;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        pw_eff_d    = pw_eff_q;
        amp_d       = amp_q;
        src_d       = src_q;
        delivered_d = delivered_q;
        done_d      = 1'b0;
        drop_inc    = 2'd0;

        case (state_q)
            IDLE: begin
                if (bus.enable && (bus.pace_req || bus.test_req)) begin
                    state_d     = CHARGE;
                    cnt_d       = CNT_WIDTH'(CHARGE_CYC - 1);
                    pw_eff_d    = pw_clamped;
                    amp_d       = bus.cfg_amp;
                    src_d       = ~bus.pace_req;
                    delivered_d = 1'b0;
                    if (bus.pace_req && bus.test_req) begin
                        drop_inc = 2'd1;
                    end
                end
            end
            CHARGE: begin
                // Losing enable while charging dumps the capacitor via recharge.
                if (!bus.enable) begin
                    state_d = RECHARGE;
                    cnt_d   = CNT_WIDTH'(RECHARGE_CYC - 1);
                end else if (cnt_q == '0) begin
                    state_d     = DELIVER;
                    cnt_d       = CNT_WIDTH'(pw_eff_q) - 1'b1;
                    delivered_d = 1'b1;
                end
            end
            DELIVER: begin
                if (cnt_q == '0) begin
                    state_d = RECHARGE;
                    cnt_d   = CNT_WIDTH'(RECHARGE_CYC - 1);
                end
            end
            RECHARGE: begin
                if (cnt_q == '0) begin
                    state_d = BLANK;
                    cnt_d   = CNT_WIDTH'(BLANK_CYC - 1);
                end
            end
            BLANK: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = delivered_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (state_q != IDLE) begin
            drop_inc = {1'b0, bus.pace_req} + {1'b0, bus.test_req};
        end

        drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Output switches are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pw_eff_q    <= '0;
            amp_q       <= '0;
            src_q       <= 1'b0;
            delivered_q <= 1'b0;
            drop_q      <= '0;
            done_q      <= 1'b0;
            charge_q    <= 1'b0;
            pulse_q     <= 1'b0;
            recharge_q  <= 1'b0;
            blank_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pw_eff_q    <= pw_eff_d;
            amp_q       <= amp_d;
            src_q       <= src_d;
            delivered_q <= delivered_d;
            drop_q      <= drop_d;
            done_q      <= done_d;
            charge_q    <= (state_d == CHARGE);
            pulse_q     <= (state_d == DELIVER);
            recharge_q  <= (state_d == RECHARGE);
            blank_q     <= (state_d != IDLE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.charge_en   = charge_q;
    assign bus.pulse_en    = pulse_q;
    assign bus.recharge_en = recharge_q;
    assign bus.sense_blank = blank_q;
    assign bus.busy        = busy_q;
    assign bus.amp_out     = amp_q;
    assign bus.src_test    = src_q;
    assign bus.pace_done   = done_q;
    assign bus.drop_cnt    = drop_q;

endmodule

// File: tb/tb_pace_output_sequencer.sv
// Randomized bench for pace_output_sequencer against a timeline model of each pace sequence.
module tb_pace_output_sequencer;
    import pacemaker_pkg::*;

    localparam int CHG = 8;
    localparam int RCH = 20;
    localparam int BLK = 400;
    localparam int MPW = 150;

    logic clk = 1'b0;
    logic rst;

    pace_output_sequencer_if #(.PW_WIDTH(8)) bus ();

    pace_output_sequencer #(
        .CHARGE_CYC  (CHG),
        .RECHARGE_CYC(RCH),
        .BLANK_CYC   (BLK),
        .MAX_PW_CYC  (MPW),
        .PW_WIDTH    (8),
        .CNT_WIDTH   (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          t;

    // Model: one sequence described by its start cycle, clamped width and abort offset.
    bit          have_seq;
    int          start;
    int          m_pw;
    int          abort_a;
    bit          m_src;
    logic [3:0]  m_amp;
    int          m_drops;
    int          pulse_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    function automatic int seq_end();
        return (abort_a != 0) ? abort_a + RCH + BLK : CHG + m_pw + RCH + BLK;
    endfunction

    function automatic bit m_busy(input int tt);
        int k;
        k = tt - start;
        return have_seq && (k >= 1) && (k <= seq_end());
    endfunction

    function automatic logic [10:0] m_outs(input int tt);
        int k, c_end, p_end, r_end, b_end;
        bit ch, pu, re, bl, bu, dn;
        ch = 0; pu = 0; re = 0; bl = 0; bu = 0; dn = 0;
        if (have_seq) begin
            k = tt - start;
            if (abort_a != 0) begin
                c_end = abort_a;
                p_end = abort_a;
            end else begin
                c_end = CHG;
                p_end = CHG + m_pw;
            end
            r_end = p_end + RCH;
            b_end = r_end + BLK;
            ch = (k >= 1) && (k <= c_end);
            pu = (k > c_end) && (k <= p_end);
            re = (k > p_end) && (k <= r_end);
            bu = (k >= 1) && (k <= b_end);
            bl = bu;
            dn = (abort_a == 0) && (k == b_end + 1);
        end
        return {ch, pu, re, bl, bu, m_src, dn, m_amp};
    endfunction

    function automatic logic [10:0] dut_outs();
        return {bus.charge_en, bus.pulse_en, bus.recharge_en, bus.sense_blank,
                bus.busy, bus.src_test, bus.pace_done, bus.amp_out};
    endfunction

    task automatic model_reset();
        have_seq = 0;
        start    = 0;
        m_pw     = 0;
        abort_a  = 0;
        m_src    = 0;
        m_amp    = '0;
        m_drops  = 0;
    endtask

    task automatic do_cycle(input bit en, input bit pr, input bit tr,
                            input logic [7:0] pw, input logic [3:0] amp);
        bit busy_now;
        check("outs", 32'(dut_outs()), 32'(m_outs(t)));
        check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
        if (bus.pulse_en) pulse_seen++;

        bus.enable   = en;
        bus.pace_req = pr;
        bus.test_req = tr;
        bus.cfg_pw   = pw;
        bus.cfg_amp  = amp;

        busy_now = m_busy(t);
        if (busy_now) begin
            m_drops = m_drops + int'(pr) + int'(tr);
            if (!en && abort_a == 0 && (t - start) >= 1 && (t - start) <= CHG)
                abort_a = t - start;
        end else if (en && (pr || tr)) begin
            if (pr && tr) m_drops = m_drops + 1;
            have_seq = 1;
            start    = t;
            m_pw     = (pw == 0) ? 1 : ((int'(pw) > MPW) ? MPW : int'(pw));
            abort_a  = 0;
            m_src    = !pr;
            m_amp    = amp;
        end
        if (m_drops > 255) m_drops = 255;

        @(negedge clk);
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            do_cycle(1'b1, 1'b0, 1'b0, 8'($urandom), 4'($urandom));
    endtask

    initial begin
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.pace_req = 1'b0;
        bus.test_req = 1'b0;
        bus.cfg_pw   = '0;
        bus.cfg_amp  = '0;
        t            = 0;
        pulse_seen   = 0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_outs", 32'(dut_outs()), 32'd0);
        check("rst_drop", 32'(bus.drop_cnt), 32'd0);
        rst = 1'b0;

        // Basic demand pace, width 40, amplitude 5
        pulse_seen = 0;
        do_cycle(1, 1, 0, 8'd40, 4'd5);
        idle(470);
        check("pw40_len", 32'(pulse_seen), 32'd40);

        // Simultaneous requests, then a lone test request
        do_cycle(1, 1, 1, 8'd40, 4'd3);
        idle(470);
        do_cycle(1, 0, 1, 8'd10, 4'd9);
        idle(450);

        // Width clamps
        pulse_seen = 0;
        do_cycle(1, 1, 0, 8'd0, 4'd2);
        idle(440);
        check("pw0_len", 32'(pulse_seen), 32'd1);
        pulse_seen = 0;
        do_cycle(1, 1, 0, 8'd255, 4'd2);
        idle(590);
        check("pw255_len", 32'(pulse_seen), 32'd150);

        // Requests while busy, then saturation
        do_cycle(1, 1, 0, 8'd40, 4'd7);
        for (int c = 1; c <= 470; c++)
            do_cycle(1, (c == 100) || (c == 200), 1'b0, 8'($urandom), 4'($urandom));
        do_cycle(1, 1, 0, 8'd40, 4'd1);
        for (int c = 0; c < 300; c++)
            do_cycle(1, 1'b1, 1'($urandom), 8'($urandom), 4'($urandom));
        idle(200);
        check("drop_sat", 32'(bus.drop_cnt), 32'd255);

        // Enable drop in CHARGE aborts; in DELIVER it does not truncate
        pulse_seen = 0;
        do_cycle(1, 1, 0, 8'd40, 4'd4);
        for (int c = 1; c <= 3; c++) do_cycle(1, 0, 0, 8'd40, 4'd4);
        do_cycle(0, 0, 0, 8'd40, 4'd4);
        idle(430);
        check("abort_nopulse", 32'(pulse_seen), 32'd0);
        pulse_seen = 0;
        do_cycle(1, 1, 0, 8'd40, 4'd6);
        for (int c = 1; c <= 8; c++) do_cycle(1, 0, 0, 8'd40, 4'd6);
        for (int c = 9; c <= 20; c++) do_cycle(0, 0, 0, 8'd40, 4'd6);
        idle(450);
        check("deliver_full", 32'(pulse_seen), 32'd40);

        // Asynchronous reset mid-DELIVER
        do_cycle(1, 1, 0, 8'd40, 4'd8);
        for (int c = 0; c < 15; c++) do_cycle(1, 0, 0, 8'd40, 4'd8);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outs", 32'(dut_outs()), 32'd0);
        check("rst_async_drop", 32'(bus.drop_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        t++;
        rst = 1'b0;
        do_cycle(1, 1, 0, 8'd20, 4'd3);
        idle(460);

        // Randomized traffic
        for (int c = 0; c < 8000; c++)
            do_cycle($urandom_range(0, 99) < 95,
                     $urandom_range(0, 199) == 0,
                     $urandom_range(0, 199) == 0,
                     8'($urandom), 4'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
